mem_port_arbiter: RTL and testbench

Two-requester arbiter sharing the single block-wide main-memory port between the instruction cache (refill reads only) and the data cache (refill reads and dirty write-backs). It sits between `i_cache`/`d_cache` and the shared main memory. It runs one memory transaction at a time and holds the grant until that transaction completes. The data cache has priority, and a bounded-starvation counter guarantees the instruction cache forward progress.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_if.sv | 47 ++++
 rtl/mem_port_arbiter_starve.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter package: FSM state encoding and default bus widths,
// reused by the cache controllers and the memory models.
package mem_port_arbiter_pkg;

   localparam int DEF_ADDR_W     = 28;
   localparam int DEF_BLOCK_W    = 128;
   localparam int DEF_STARVE_MAX = 4;
   localparam int STARVE_W       = 3;

   typedef enum logic [2:0] {
      ARB_IDLE   = 3'd0,
      ARB_GNT_I  = 3'd1,
      ARB_GNT_D  = 3'd2,
      ARB_DONE_I = 3'd3,
      ARB_DONE_D = 3'd4
   } arb_state_e;

   function automatic logic arb_is_grant(arb_state_e s);
      return (s == ARB_GNT_I) || (s == ARB_GNT_D);
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of I-cache, D-cache and main-memory signals around the arbiter.
// slave: the arbiter itself; master: the caches plus memory around it.
interface mem_port_arbiter_if
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int BLOCK_W = DEF_BLOCK_W
);

   logic               I_READ;
   logic [ADDR_W-1:0]  I_ADDR;
   logic [BLOCK_W-1:0] I_READDATA;
   logic               I_BUSYWAIT;

   logic               D_READ;
   logic               D_WRITE;
   logic [ADDR_W-1:0]  D_ADDR;
   logic [BLOCK_W-1:0] D_WRITEDATA;
   logic [BLOCK_W-1:0] D_READDATA;
   logic               D_BUSYWAIT;

   logic               MEM_READ;
   logic               MEM_WRITE;
   logic [ADDR_W-1:0]  MEM_ADDR;
   logic [BLOCK_W-1:0] MEM_WRITEDATA;
   logic [BLOCK_W-1:0] MEM_READDATA;
   logic               MEM_BUSYWAIT;

   modport slave (
      input  I_READ, I_ADDR,
      output I_READDATA, I_BUSYWAIT,
      input  D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
      output D_READDATA, D_BUSYWAIT,
      output MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA,
      input  MEM_READDATA, MEM_BUSYWAIT
   );

   modport master (
      output I_READ, I_ADDR,
      input  I_READDATA, I_BUSYWAIT,
      output D_READ, D_WRITE, D_ADDR, D_WRITEDATA,
      input  D_READDATA, D_BUSYWAIT,
      input  MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WRITEDATA,
      output MEM_READDATA, MEM_BUSYWAIT
   );

endinterface

// File: rtl/mem_port_arbiter_starve.sv
// Saturating starvation counter: clr wins over inc, holds at MAX.
// Ports: clk, rst_n, inc, clr in; cnt (count) and sat (cnt == MAX) out.
module arb_starve_counter #(
   parameter int MAX = 4,
   parameter int W   = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt,
   output logic         sat
);

   localparam logic [W-1:0] MAX_C = W'(MAX);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign cnt = cnt_q;
   assign sat = (cnt_q == MAX_C);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && !sat) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// I/D cache to main-memory port arbiter, D priority with I starvation bound.
// Ports: CLK, RESET (async, active low), bus (slave view of the cache/mem bundle).
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int BLOCK_W    = DEF_BLOCK_W,
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic                CLK,
   input  logic                RESET,
   mem_port_arbiter_if.slave   bus
);

   arb_state_e         state_q;
   arb_state_e         state_d;

   logic               seen_busy_q;
   logic               seen_busy_d;
   logic               mem_read_q;
   logic               mem_read_d;
   logic               mem_write_q;
   logic               mem_write_d;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [ADDR_W-1:0]  mem_addr_d;
   logic [BLOCK_W-1:0] mem_wdata_q;
   logic [BLOCK_W-1:0] mem_wdata_d;
   logic [BLOCK_W-1:0] i_rdata_q;
   logic [BLOCK_W-1:0] i_rdata_d;
   logic [BLOCK_W-1:0] d_rdata_q;
   logic [BLOCK_W-1:0] d_rdata_d;

   logic               i_req;
   logic               d_req;
   logic               in_idle;
   logic               in_gnt;
   logic               done_mem;
   logic               gnt_i_ent;
   logic               gnt_d_ent;
   logic               starve_inc;
   logic               starve_clr;
   logic               starve_sat;
   logic [STARVE_W-1:0] starve_cnt;

   assign i_req    = bus.I_READ;
   assign d_req    = bus.D_READ | bus.D_WRITE;
   assign in_idle  = (state_q == ARB_IDLE);
   assign in_gnt   = arb_is_grant(state_q);
   // Memory must have been seen busy before its low level means "done".
   assign done_mem = seen_busy_q & ~bus.MEM_BUSYWAIT;

   assign gnt_i_ent = in_idle & (state_d == ARB_GNT_I);
   assign gnt_d_ent = in_idle & (state_d == ARB_GNT_D);

   // Only D grants that overtake a waiting I count toward starvation.
   assign starve_inc = gnt_d_ent & i_req;
   assign starve_clr = gnt_i_ent | (in_idle & ~i_req);

   arb_starve_counter #(
      .MAX (STARVE_MAX),
      .W   (STARVE_W)
   ) u_starve (
      .clk   (CLK),
      .rst_n (RESET),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .cnt   (starve_cnt),
      .sat   (starve_sat)
   );

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ARB_IDLE: begin
            if (i_req && starve_sat) begin
               state_d = ARB_GNT_I;
            end else if (d_req) begin
               state_d = ARB_GNT_D;
            end else if (i_req) begin
               state_d = ARB_GNT_I;
            end
         end
         ARB_GNT_I: begin
            if (done_mem) state_d = ARB_DONE_I;
         end
         ARB_GNT_D: begin
            if (done_mem) state_d = ARB_DONE_D;
         end
         ARB_DONE_I: state_d = ARB_IDLE;
         ARB_DONE_D: state_d = ARB_IDLE;
         default:    state_d = ARB_IDLE;
      endcase
   end

   always_comb begin
      bus.I_BUSYWAIT = i_req & (state_q != ARB_DONE_I);
      bus.D_BUSYWAIT = d_req & (state_q != ARB_DONE_D);

      seen_busy_d = seen_busy_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;

      unique case (1'b1)
         gnt_i_ent: begin
            mem_read_d  = 1'b1;
            mem_write_d = 1'b0;
            mem_addr_d  = bus.I_ADDR;
            seen_busy_d = 1'b0;
         end
         gnt_d_ent: begin
            mem_read_d  = bus.D_READ;
            mem_write_d = bus.D_WRITE;
            mem_addr_d  = bus.D_ADDR;
            mem_wdata_d = bus.D_WRITEDATA;
            seen_busy_d = 1'b0;
         end
         (in_gnt && done_mem): begin
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            seen_busy_d = 1'b0;
            if (state_q == ARB_GNT_I) begin
               i_rdata_d = bus.MEM_READDATA;
            end else if (!mem_write_q) begin
               d_rdata_d = bus.MEM_READDATA;
            end
         end
         (in_gnt && !done_mem): begin
            seen_busy_d = seen_busy_q | bus.MEM_BUSYWAIT;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         seen_busy_q <= 1'b0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         i_rdata_q   <= '0;
         d_rdata_q   <= '0;
      end else begin
         seen_busy_q <= seen_busy_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
      end
   end

   assign bus.MEM_READ      = mem_read_q;
   assign bus.MEM_WRITE     = mem_write_q;
   assign bus.MEM_ADDR      = mem_addr_q;
   assign bus.MEM_WRITEDATA = mem_wdata_q;
   assign bus.I_READDATA    = i_rdata_q;
   assign bus.D_READDATA    = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a busy-counting memory.
// Memory answers {4{4'h0,addr}} unless fixed_mode selects rdata_next.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic CLK = 1'b0;
   logic RESET;

   int checks = 0;
   int errors = 0;

   int           lat = 5;
   bit           fixed_mode = 1'b0;
   logic [127:0] rdata_next = '0;

   int           m_cnt = 0;
   bit           m_act = 1'b0;
   logic [27:0]  m_addr = '0;
   int           proto_err = 0;
   logic [27:0]  txn_addr[$];
   bit           txn_wr[$];

   mem_port_arbiter_if bus ();

   mem_port_arbiter dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Memory model: busy for 'lat' cycles after it sees a command.
   always @(posedge CLK) begin
      #1;
      if (!RESET) begin
         m_act = 1'b0;
         m_cnt = 0;
         bus.MEM_BUSYWAIT = 1'b0;
         bus.MEM_READDATA = '0;
      end else if (m_act) begin
         m_cnt = m_cnt - 1;
         if (m_cnt == 0) begin
            bus.MEM_BUSYWAIT = 1'b0;
            bus.MEM_READDATA = fixed_mode ? rdata_next : {4{4'h0, m_addr}};
            m_act = 1'b0;
         end
      end else if (bus.MEM_READ || bus.MEM_WRITE) begin
         m_act = 1'b1;
         m_cnt = lat;
         m_addr = bus.MEM_ADDR;
         bus.MEM_BUSYWAIT = 1'b1;
         txn_addr.push_back(bus.MEM_ADDR);
         txn_wr.push_back(bus.MEM_WRITE);
      end
      if (bus.MEM_READ && bus.MEM_WRITE) proto_err++;
   end

   task automatic tick;
      @(posedge CLK);
      #2;
   endtask

   task automatic test_reset;
      RESET = 1'b0;
      bus.I_READ = 1'b0;
      bus.I_ADDR = '0;
      bus.D_READ = 1'b0;
      bus.D_WRITE = 1'b0;
      bus.D_ADDR = '0;
      bus.D_WRITEDATA = '0;
      tick;
      tick;
      checks++;
      if ({bus.MEM_READ, bus.MEM_WRITE} !== 2'b00) begin
         errors++;
         $display("FAIL reset_cmd got %b want 00", {bus.MEM_READ, bus.MEM_WRITE});
      end
      checks++;
      if (bus.MEM_ADDR !== 28'h0 || bus.MEM_WRITEDATA !== 128'h0) begin
         errors++;
         $display("FAIL reset_addr_wdata got %h %h want 0", bus.MEM_ADDR, bus.MEM_WRITEDATA);
      end
      checks++;
      if (bus.I_READDATA !== 128'h0 || bus.D_READDATA !== 128'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h %h want 0", bus.I_READDATA, bus.D_READDATA);
      end
      checks++;
      if (dut.state_q !== ARB_IDLE || dut.starve_cnt !== 3'd0) begin
         errors++;
         $display("FAIL reset_state got %0d cnt %0d want 0 0", dut.state_q, dut.starve_cnt);
      end
      bus.I_READ = 1'b1;
      #1;
      checks++;
      if (bus.I_BUSYWAIT !== 1'b1 || bus.D_BUSYWAIT !== 1'b0) begin
         errors++;
         $display("FAIL reset_busywait got %b%b want 10", bus.I_BUSYWAIT, bus.D_BUSYWAIT);
      end
      bus.I_READ = 1'b0;
      RESET = 1'b1;
      tick;
   endtask

   task automatic test_single_i;
      int c;
      fixed_mode = 1'b1;
      rdata_next = 128'hDEADBEEF_00000000_00000000_00000001;
      lat = 5;
      txn_addr.delete();
      txn_wr.delete();
      bus.I_ADDR = 28'h0000010;
      bus.I_READ = 1'b1;
      #1;
      checks++;
      if (bus.I_BUSYWAIT !== 1'b1 || bus.MEM_READ !== 1'b0) begin
         errors++;
         $display("FAIL single_same_cycle got bw %b rd %b want 1 0", bus.I_BUSYWAIT, bus.MEM_READ);
      end
      tick;
      checks++;
      if (bus.MEM_READ !== 1'b1 || bus.MEM_WRITE !== 1'b0 || bus.MEM_ADDR !== 28'h10) begin
         errors++;
         $display("FAIL single_cmd got rd %b wr %b addr %h want 1 0 10",
                  bus.MEM_READ, bus.MEM_WRITE, bus.MEM_ADDR);
      end
      c = 0;
      for (int k = 1; k <= 20; k++) begin
         tick;
         if (bus.I_BUSYWAIT === 1'b0) begin
            c = k;
            break;
         end
      end
      checks++;
      if (c != 6) begin
         errors++;
         $display("FAIL single_latency got %0d want 6", c);
      end
      checks++;
      if (bus.I_READDATA !== 128'hDEADBEEF_00000000_00000000_00000001) begin
         errors++;
         $display("FAIL single_rdata got %h want deadbeef..0001", bus.I_READDATA);
      end
      checks++;
      if (bus.MEM_READ !== 1'b0) begin
         errors++;
         $display("FAIL single_cmd_clear got %b want 0", bus.MEM_READ);
      end
      bus.I_READ = 1'b0;
      tick;
      checks++;
      if (dut.state_q !== ARB_IDLE || bus.I_BUSYWAIT !== 1'b0) begin
         errors++;
         $display("FAIL single_idle got %0d bw %b want 0 0", dut.state_q, bus.I_BUSYWAIT);
      end
      checks++;
      if (bus.I_READDATA !== 128'hDEADBEEF_00000000_00000000_00000001) begin
         errors++;
         $display("FAIL single_rdata_hold got %h", bus.I_READDATA);
      end
      fixed_mode = 1'b0;
   endtask

   task automatic test_simultaneous;
      int dd;
      int ic;
      lat = 2;
      dd = -1;
      ic = -1;
      txn_addr.delete();
      txn_wr.delete();
      bus.I_ADDR = 28'h100;
      bus.D_ADDR = 28'h200;
      bus.I_READ = 1'b1;
      bus.D_READ = 1'b1;
      #1;
      checks++;
      if ({bus.I_BUSYWAIT, bus.D_BUSYWAIT} !== 2'b11) begin
         errors++;
         $display("FAIL simul_busywait got %b want 11", {bus.I_BUSYWAIT, bus.D_BUSYWAIT});
      end
      for (int k = 1; k <= 60; k++) begin
         tick;
         if (k == 1) begin
            checks++;
            if (bus.MEM_ADDR !== 28'h200 || bus.MEM_READ !== 1'b1) begin
               errors++;
               $display("FAIL simul_d_first got %h rd %b want 200 1", bus.MEM_ADDR, bus.MEM_READ);
            end
         end
         if (bus.D_READ && !bus.D_BUSYWAIT) begin
            dd = k;
            bus.D_READ = 1'b0;
         end
         if (bus.MEM_READ && bus.MEM_ADDR == 28'h100 && ic < 0) ic = k;
         if (bus.I_READ && !bus.I_BUSYWAIT) bus.I_READ = 1'b0;
         if (!bus.I_READ && !bus.D_READ) break;
      end
      checks++;
      if (dd < 0 || ic != dd + 2) begin
         errors++;
         $display("FAIL simul_i_timing got i_cmd %0d d_done %0d want i_cmd = d_done+2", ic, dd);
      end
      checks++;
      if (txn_addr.size() != 2 || txn_addr[0] !== 28'h200 || txn_addr[1] !== 28'h100) begin
         errors++;
         $display("FAIL simul_order got n=%0d want 200 then 100", txn_addr.size());
      end
      checks++;
      if (bus.D_READDATA !== {4{32'h00000200}} || bus.I_READDATA !== {4{32'h00000100}}) begin
         errors++;
         $display("FAIL simul_rdata got %h %h", bus.D_READDATA, bus.I_READDATA);
      end
      checks++;
      if (proto_err != 0) begin
         errors++;
         $display("FAIL simul_both_cmd got %0d want 0", proto_err);
      end
      tick;
   endtask

   task automatic test_starvation;
      bit got_i;
      int nd;
      lat = 2;
      got_i = 1'b0;
      txn_addr.delete();
      txn_wr.delete();
      bus.I_ADDR = 28'h300;
      bus.D_ADDR = 28'h400;
      bus.I_READ = 1'b1;
      bus.D_READ = 1'b1;
      for (int k = 1; k <= 200; k++) begin
         tick;
         if (txn_addr.size() >= 5 && bus.D_READ) bus.D_READ = 1'b0;
         if (bus.I_READ && !bus.I_BUSYWAIT) begin
            got_i = 1'b1;
            break;
         end
      end
      nd = 0;
      for (int k = 0; k < 4 && k < txn_addr.size(); k++) begin
         if (txn_addr[k] == 28'h400) nd++;
      end
      checks++;
      if (!got_i || txn_addr.size() != 5 || nd != 4 || txn_addr[4] !== 28'h300) begin
         errors++;
         $display("FAIL starve_order got i %b n=%0d d_first4=%0d want 1 5 4",
                  got_i, txn_addr.size(), nd);
      end
      checks++;
      if (dut.starve_cnt !== 3'd0) begin
         errors++;
         $display("FAIL starve_cnt_clear got %0d want 0", dut.starve_cnt);
      end
      checks++;
      if (bus.I_READDATA !== {4{32'h00000300}}) begin
         errors++;
         $display("FAIL starve_i_rdata got %h", bus.I_READDATA);
      end
      bus.I_READ = 1'b0;
      bus.D_READ = 1'b0;
      tick;
   endtask

   task automatic test_d_writeback;
      logic [127:0] wd;
      int wcyc;
      int bad;
      bit done;
      wd = 128'h1111_1111_1111_1111_2222_2222_2222_2222;
      lat = 3;
      wcyc = 0;
      bad = 0;
      done = 1'b0;
      txn_addr.delete();
      txn_wr.delete();
      bus.D_ADDR = 28'h3F;
      bus.D_WRITEDATA = wd;
      bus.D_WRITE = 1'b1;
      tick;
      checks++;
      if (bus.MEM_WRITE !== 1'b1 || bus.MEM_READ !== 1'b0) begin
         errors++;
         $display("FAIL wb_cmd got wr %b rd %b want 1 0", bus.MEM_WRITE, bus.MEM_READ);
      end
      for (int k = 0; k < 30; k++) begin
         if (bus.MEM_WRITE) begin
            wcyc++;
            if (bus.MEM_WRITEDATA !== wd || bus.MEM_ADDR !== 28'h3F) bad++;
         end
         tick;
         if (!bus.D_BUSYWAIT) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done || wcyc != 4 || bad != 0) begin
         errors++;
         $display("FAIL wb_stable got done %b cycles %0d bad %0d want 1 4 0", done, wcyc, bad);
      end
      checks++;
      if (bus.D_READDATA !== {4{32'h00000400}}) begin
         errors++;
         $display("FAIL wb_d_rdata got %h want 4x00000400", bus.D_READDATA);
      end
      checks++;
      if (txn_wr.size() != 1 || txn_wr[0] !== 1'b1) begin
         errors++;
         $display("FAIL wb_txn got n=%0d want one write", txn_wr.size());
      end
      bus.D_WRITE = 1'b0;
      tick;
   endtask

   task automatic test_reset_mid_grant;
      bit done;
      lat = 6;
      done = 1'b0;
      txn_addr.delete();
      txn_wr.delete();
      bus.I_ADDR = 28'h20;
      bus.I_READ = 1'b1;
      tick;
      tick;
      tick;
      RESET = 1'b0;
      #1;
      checks++;
      if ({bus.MEM_READ, bus.MEM_WRITE} !== 2'b00) begin
         errors++;
         $display("FAIL rst_mid_cmd got %b want 00", {bus.MEM_READ, bus.MEM_WRITE});
      end
      checks++;
      if (dut.state_q !== ARB_IDLE || bus.I_READDATA !== 128'h0 || bus.D_READDATA !== 128'h0) begin
         errors++;
         $display("FAIL rst_mid_state got %0d %h %h", dut.state_q, bus.I_READDATA, bus.D_READDATA);
      end
      checks++;
      if (bus.I_BUSYWAIT !== 1'b1) begin
         errors++;
         $display("FAIL rst_mid_busywait got %b want 1", bus.I_BUSYWAIT);
      end
      bus.I_READ = 1'b0;
      tick;
      tick;
      RESET = 1'b1;
      lat = 3;
      bus.I_ADDR = 28'h24;
      bus.I_READ = 1'b1;
      for (int k = 0; k < 30; k++) begin
         tick;
         if (!bus.I_BUSYWAIT) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done || bus.I_READDATA !== {4{32'h00000024}}) begin
         errors++;
         $display("FAIL rst_recover got done %b rdata %h", done, bus.I_READDATA);
      end
      checks++;
      if (txn_addr.size() != 2 || txn_addr[1] !== 28'h24) begin
         errors++;
         $display("FAIL rst_recover_txn got n=%0d want 2", txn_addr.size());
      end
      bus.I_READ = 1'b0;
      tick;
   endtask

   task automatic test_drop_early;
      bit seen_done;
      lat = 5;
      seen_done = 1'b0;
      txn_addr.delete();
      txn_wr.delete();
      bus.I_ADDR = 28'h30;
      bus.I_READ = 1'b1;
      tick;
      tick;
      bus.I_READ = 1'b0;
      #1;
      checks++;
      if (bus.I_BUSYWAIT !== 1'b0 || bus.MEM_READ !== 1'b1) begin
         errors++;
         $display("FAIL drop_mid got bw %b rd %b want 0 1", bus.I_BUSYWAIT, bus.MEM_READ);
      end
      for (int k = 0; k < 20; k++) begin
         tick;
         if (dut.state_q === ARB_DONE_I) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done || bus.I_READDATA !== {4{32'h00000030}}) begin
         errors++;
         $display("FAIL drop_done got seen %b rdata %h", seen_done, bus.I_READDATA);
      end
      checks++;
      if (txn_addr.size() != 1 || bus.MEM_READ !== 1'b0 || dut.state_q !== ARB_IDLE) begin
         errors++;
         $display("FAIL drop_no_second got n=%0d rd %b st %0d want 1 0 0",
                  txn_addr.size(), bus.MEM_READ, dut.state_q);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset;
      test_single_i;
      test_simultaneous;
      test_starvation;
      test_d_writeback;
      test_reset_mid_grant;
      test_drop_early;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
